// File: rtl/lsu_pkg.sv
// Shared load/store types and helpers for the data TCM path.
// Pure declarations and functions; no state, no latency, no flow control.
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } data_type_e;

  // Raw 2-bit type is kept so the illegal encoding 11 survives into the record.
  typedef struct packed {
    logic       port;
    logic       we;
    logic [1:0] dtype;
    logic [1:0] offset;
    logic       sign_ext;
    logic       err;
  } resp_t;

  function automatic logic [3:0] be_gen(input logic [1:0] dtype, input logic [1:0] offset);
    logic [3:0] be;
    case (dtype)
      BYTE:    be = 4'b0001 << offset;
      HALF:    be = 4'b0011 << offset;
      WORD:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Flags both misalignment and the illegal type encoding.
  function automatic logic misaligned(input logic [1:0] dtype, input logic [1:0] addr);
    logic bad;
    case (dtype)
      BYTE:    bad = 1'b0;
      HALF:    bad = addr[0];
      WORD:    bad = |addr;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester ports and TCM port of the data memory arbiter.
// Plain wiring bundle; timing and flow control are owned by the arbiter.
interface data_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  p0_req_i;
  logic [ADDR_WIDTH-1:0] p0_addr_i;
  logic                  p0_we_i;
  logic [1:0]            p0_type_i;
  logic                  p0_sign_ext_i;
  logic [DATA_WIDTH-1:0] p0_wdata_i;
  logic                  p0_gnt_o;
  logic                  p0_rvalid_o;
  logic [DATA_WIDTH-1:0] p0_rdata_o;
  logic                  p0_err_o;

  logic                  p1_req_i;
  logic [ADDR_WIDTH-1:0] p1_addr_i;
  logic                  p1_we_i;
  logic [1:0]            p1_type_i;
  logic                  p1_sign_ext_i;
  logic [DATA_WIDTH-1:0] p1_wdata_i;
  logic                  p1_gnt_o;
  logic                  p1_rvalid_o;
  logic [DATA_WIDTH-1:0] p1_rdata_o;
  logic                  p1_err_o;

  logic                  mem_req_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_we_o;
  logic [3:0]            mem_be_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  p0_req_i, p0_addr_i, p0_we_i, p0_type_i, p0_sign_ext_i, p0_wdata_i,
    output p0_gnt_o, p0_rvalid_o, p0_rdata_o, p0_err_o,
    input  p1_req_i, p1_addr_i, p1_we_i, p1_type_i, p1_sign_ext_i, p1_wdata_i,
    output p1_gnt_o, p1_rvalid_o, p1_rdata_o, p1_err_o,
    output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output p0_req_i, p0_addr_i, p0_we_i, p0_type_i, p0_sign_ext_i, p0_wdata_i,
    input  p0_gnt_o, p0_rvalid_o, p0_rdata_o, p0_err_o,
    output p1_req_i, p1_addr_i, p1_we_i, p1_type_i, p1_sign_ext_i, p1_wdata_i,
    input  p1_gnt_o, p1_rvalid_o, p1_rdata_o, p1_err_o,
    input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/lsu_rdata_align.sv
// Moves the addressed lane of a TCM read word to bit 0 and sign/zero-extends it.
// Combinational, zero latency; no flow control.
module lsu_rdata_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  dtype,
  input  logic        sign_ext,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (dtype)
      BYTE:    data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      HALF:    data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      WORD:    data = shifted;
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin sharing of the single-ported data TCM between two requesters.
// Grant is combinational; response (rvalid) follows exactly one cycle after grant.
// No wait states: one access per cycle, the loser of contention waits holding req.
module data_mem_arbiter
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input logic             clk,
  input logic             rst_n,
  data_mem_arbiter_if.slave bus
);

  logic                  rr_q;
  logic                  any_req;
  logic                  gnt_port;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_we;
  logic [1:0]            sel_type;
  logic                  sel_sign_ext;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_err;
  logic                  mem_go;
  logic [DATA_WIDTH-1:0] steered_wdata;

  logic                  resp_vld_q;
  resp_t                 resp_q;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] resp_data;

  // Pointer only matters under contention; a lone requester always wins.
  always_comb begin
    any_req      = bus.p0_req_i | bus.p1_req_i;
    gnt_port     = (bus.p0_req_i && bus.p1_req_i) ? rr_q : bus.p1_req_i;
    sel_addr     = gnt_port ? bus.p1_addr_i     : bus.p0_addr_i;
    sel_we       = gnt_port ? bus.p1_we_i       : bus.p0_we_i;
    sel_type     = gnt_port ? bus.p1_type_i     : bus.p0_type_i;
    sel_sign_ext = gnt_port ? bus.p1_sign_ext_i : bus.p0_sign_ext_i;
    sel_wdata    = gnt_port ? bus.p1_wdata_i    : bus.p0_wdata_i;
    sel_err      = misaligned(sel_type, sel_addr[1:0]);
    mem_go       = any_req & ~sel_err;

    case (sel_type)
      BYTE:    steered_wdata = {4{sel_wdata[7:0]}};
      HALF:    steered_wdata = {2{sel_wdata[15:0]}};
      default: steered_wdata = sel_wdata;
    endcase
  end

  assign bus.p0_gnt_o = any_req & ~gnt_port;
  assign bus.p1_gnt_o = any_req &  gnt_port;

  // Illegal requests are consumed but leave the TCM port completely idle.
  assign bus.mem_req_o   = mem_go;
  assign bus.mem_we_o    = mem_go & sel_we;
  assign bus.mem_be_o    = mem_go ? be_gen(sel_type, sel_addr[1:0]) : 4'b0000;
  assign bus.mem_addr_o  = mem_go ? {sel_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign bus.mem_wdata_o = mem_go ? steered_wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= 1'b0;
      resp_vld_q <= 1'b0;
      resp_q     <= '0;
    end else begin
      resp_vld_q <= any_req;
      if (any_req) begin
        rr_q            <= ~gnt_port;
        resp_q.port     <= gnt_port;
        resp_q.we       <= sel_we;
        resp_q.dtype    <= sel_type;
        resp_q.offset   <= sel_addr[1:0];
        resp_q.sign_ext <= sel_sign_ext;
        resp_q.err      <= sel_err;
      end
    end
  end

  lsu_rdata_align u_rdata_align (
    .rdata    (bus.mem_rdata_i),
    .offset   (resp_q.offset),
    .dtype    (resp_q.dtype),
    .sign_ext (resp_q.sign_ext),
    .data     (load_data)
  );

  // Stores and errored accesses return zero data.
  assign resp_data = (resp_vld_q && !resp_q.we && !resp_q.err) ? load_data : '0;

  assign bus.p0_rvalid_o = resp_vld_q & ~resp_q.port;
  assign bus.p1_rvalid_o = resp_vld_q &  resp_q.port;
  assign bus.p0_rdata_o  = resp_q.port ? '0 : resp_data;
  assign bus.p1_rdata_o  = resp_q.port ? resp_data : '0;
  assign bus.p0_err_o    = resp_vld_q & ~resp_q.port & resp_q.err;
  assign bus.p1_err_o    = resp_vld_q &  resp_q.port & resp_q.err;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: grants, lane steering, extension, errors, reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_data_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  data_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
  endtask

  task automatic drive(input logic port, input logic req, input logic [31:0] addr,
                       input logic we, input logic [1:0] typ, input logic sx,
                       input logic [31:0] wdata);
    if (port == 1'b0) begin
      bus.p0_req_i = req; bus.p0_addr_i = addr; bus.p0_we_i = we;
      bus.p0_type_i = typ; bus.p0_sign_ext_i = sx; bus.p0_wdata_i = wdata;
    end else begin
      bus.p1_req_i = req; bus.p1_addr_i = addr; bus.p1_we_i = we;
      bus.p1_type_i = typ; bus.p1_sign_ext_i = sx; bus.p1_wdata_i = wdata;
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    bus.mem_rdata_i = 32'h0;
    #1;
    check("rst_p0_gnt",    bus.p0_gnt_o,    1'b0);
    check("rst_p1_gnt",    bus.p1_gnt_o,    1'b0);
    check("rst_p0_rvalid", bus.p0_rvalid_o, 1'b0);
    check("rst_p1_rvalid", bus.p1_rvalid_o, 1'b0);
    check("rst_p0_err",    bus.p0_err_o,    1'b0);
    check("rst_p0_rdata",  bus.p0_rdata_o,  32'h0);
    check("rst_mem_req",   bus.mem_req_o,   1'b0);
    check("rst_mem_be",    {28'h0, bus.mem_be_o}, 32'h0);
    check("rst_mem_addr",  bus.mem_addr_o,  32'h0);
    #7 rst_n = 1'b1;

    // Signed byte load on port 0 from the top lane.
    next_cycle();
    drive(1'b0, 1'b1, 32'h0000_0103, 1'b0, 2'b00, 1'b1, 32'h0);
    #1;
    check("ld_p0_gnt",   bus.p0_gnt_o,  1'b1);
    check("ld_p1_gnt",   bus.p1_gnt_o,  1'b0);
    check("ld_mem_req",  bus.mem_req_o, 1'b1);
    check("ld_mem_we",   bus.mem_we_o,  1'b0);
    check("ld_mem_be",   {28'h0, bus.mem_be_o}, 32'h8);
    check("ld_mem_addr", bus.mem_addr_o, 32'h0000_0100);
    next_cycle();
    idle();
    bus.mem_rdata_i = 32'h8012_3456;
    #1;
    check("ld_p0_rvalid", bus.p0_rvalid_o, 1'b1);
    check("ld_p1_rvalid", bus.p1_rvalid_o, 1'b0);
    check("ld_p0_rdata",  bus.p0_rdata_o,  32'hFFFF_FF80);
    check("ld_p0_err",    bus.p0_err_o,    1'b0);

    // Halfword store on port 1 to the upper half.
    next_cycle();
    drive(1'b1, 1'b1, 32'h0000_0202, 1'b1, 2'b01, 1'b0, 32'h0000_BEEF);
    #1;
    check("st_p1_gnt",    bus.p1_gnt_o,    1'b1);
    check("st_mem_we",    bus.mem_we_o,    1'b1);
    check("st_mem_be",    {28'h0, bus.mem_be_o}, 32'hC);
    check("st_mem_wdata", bus.mem_wdata_o, 32'hBEEF_BEEF);
    check("st_mem_addr",  bus.mem_addr_o,  32'h0000_0200);
    next_cycle();
    idle();
    bus.mem_rdata_i = 32'hFFFF_FFFF;
    #1;
    check("st_p1_rvalid", bus.p1_rvalid_o, 1'b1);
    check("st_p0_rvalid", bus.p0_rvalid_o, 1'b0);
    check("st_p1_rdata",  bus.p1_rdata_o,  32'h0);
    check("st_p1_err",    bus.p1_err_o,    1'b0);

    // Contention: pointer is 0 here, so grants go 0,1,0,1.
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      if (i < 4) begin
        drive(1'b0, 1'b1, 32'h0000_0010, 1'b0, 2'b10, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 32'h0000_0020, 1'b0, 2'b10, 1'b0, 32'h0);
      end else begin
        idle();
      end
      bus.mem_rdata_i = 32'hA000_0000 + 32'(i);
      #1;
      if (i < 4) begin
        check("ct_p0_gnt", bus.p0_gnt_o, (i % 2) == 0);
        check("ct_p1_gnt", bus.p1_gnt_o, (i % 2) == 1);
      end
      if (i > 0) begin
        automatic logic prev = ((i - 1) % 2) == 1;
        check("ct_p0_rvalid", bus.p0_rvalid_o, !prev);
        check("ct_p1_rvalid", bus.p1_rvalid_o, prev);
        check("ct_rdata", prev ? bus.p1_rdata_o : bus.p0_rdata_o, 32'hA000_0000 + 32'(i));
      end
    end

    // Misaligned word on port 0.
    next_cycle();
    drive(1'b0, 1'b1, 32'h0000_0006, 1'b0, 2'b10, 1'b0, 32'h0);
    #1;
    check("mis_p0_gnt",  bus.p0_gnt_o,  1'b1);
    check("mis_mem_req", bus.mem_req_o, 1'b0);
    check("mis_mem_be",  {28'h0, bus.mem_be_o}, 32'h0);
    next_cycle();
    idle();
    bus.mem_rdata_i = 32'h1234_5678;
    // Illegal type 11 on port 1, issued in the same cycle as the error response.
    drive(1'b1, 1'b1, 32'h0000_0000, 1'b1, 2'b11, 1'b0, 32'hDEAD_BEEF);
    #1;
    check("mis_p0_rvalid", bus.p0_rvalid_o, 1'b1);
    check("mis_p0_err",    bus.p0_err_o,    1'b1);
    check("mis_p0_rdata",  bus.p0_rdata_o,  32'h0);
    check("ill_p1_gnt",    bus.p1_gnt_o,    1'b1);
    check("ill_mem_req",   bus.mem_req_o,   1'b0);
    check("ill_mem_we",    bus.mem_we_o,    1'b0);
    next_cycle();
    idle();
    #1;
    check("ill_p1_rvalid", bus.p1_rvalid_o, 1'b1);
    check("ill_p1_err",    bus.p1_err_o,    1'b1);
    check("ill_p1_rdata",  bus.p1_rdata_o,  32'h0);

    // Back-to-back loads on port 0, one per cycle.
    next_cycle();
    drive(1'b0, 1'b1, 32'h0000_0010, 1'b0, 2'b10, 1'b0, 32'h0);
    #1;
    check("b2b_gnt0",  bus.p0_gnt_o,   1'b1);
    check("b2b_addr0", bus.mem_addr_o, 32'h0000_0010);
    next_cycle();
    drive(1'b0, 1'b1, 32'h0000_0014, 1'b0, 2'b10, 1'b0, 32'h0);
    bus.mem_rdata_i = 32'h1111_1111;
    #1;
    check("b2b_gnt1",    bus.p0_gnt_o,    1'b1);
    check("b2b_addr1",   bus.mem_addr_o,  32'h0000_0014);
    check("b2b_rvalid0", bus.p0_rvalid_o, 1'b1);
    check("b2b_rdata0",  bus.p0_rdata_o,  32'h1111_1111);
    next_cycle();
    drive(1'b0, 1'b1, 32'h0000_0012, 1'b0, 2'b01, 1'b1, 32'h0);
    bus.mem_rdata_i = 32'h2222_2222;
    #1;
    check("b2b_be2",     {28'h0, bus.mem_be_o}, 32'hC);
    check("b2b_rvalid1", bus.p0_rvalid_o, 1'b1);
    check("b2b_rdata1",  bus.p0_rdata_o,  32'h2222_2222);
    next_cycle();
    drive(1'b0, 1'b1, 32'h0000_0011, 1'b0, 2'b00, 1'b0, 32'h0);
    bus.mem_rdata_i = 32'h8001_5555;
    #1;
    check("b2b_be3",     {28'h0, bus.mem_be_o}, 32'h2);
    check("b2b_rvalid2", bus.p0_rvalid_o, 1'b1);
    check("b2b_rdata2",  bus.p0_rdata_o,  32'hFFFF_8001);
    next_cycle();
    idle();
    bus.mem_rdata_i = 32'h0000_9A00;
    #1;
    check("b2b_rvalid3", bus.p0_rvalid_o, 1'b1);
    check("b2b_rdata3",  bus.p0_rdata_o,  32'h0000_009A);

    // Reset lands before the grant's capture edge; pointer was 1 beforehand.
    next_cycle();
    drive(1'b0, 1'b1, 32'h0000_0020, 1'b0, 2'b10, 1'b0, 32'h0);
    #1;
    check("rr_pre_gnt", bus.p0_gnt_o, 1'b1);
    #2 rst_n = 1'b0;
    next_cycle();
    idle();
    #1;
    check("rr_p0_rvalid", bus.p0_rvalid_o, 1'b0);
    check("rr_p1_rvalid", bus.p1_rvalid_o, 1'b0);
    #2 rst_n = 1'b1;
    next_cycle();
    drive(1'b0, 1'b1, 32'h0000_0030, 1'b0, 2'b10, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 32'h0000_0040, 1'b0, 2'b10, 1'b0, 32'h0);
    #1;
    check("rr_post_gnt0", bus.p0_gnt_o, 1'b1);
    check("rr_post_gnt1", bus.p1_gnt_o, 1'b0);
    next_cycle();
    idle();
    bus.mem_rdata_i = 32'h0BAD_CAFE;
    #1;
    check("rr_post_rvalid", bus.p0_rvalid_o, 1'b1);
    check("rr_post_rdata",  bus.p0_rdata_o,  32'h0BAD_CAFE);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
